// File: rtl/pipeline_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, reset
// vector, PC step and the fetch-output record seen by the decode stage.
package pipeline_fetch_pkg;

    localparam int                 XLEN_DEF     = 32;
    localparam logic [31:0]        RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]        PC_INC       = 32'd4;

    // One fetched instruction as handed to ID.
    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pc_plus4;
        logic                valid;
    } fetch_out_t;

    // A PC whose two low bits are not zero is not word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pipeline_fetch_imem_sram.sv
// Single-port synchronous-read instruction memory, one cycle read latency.
// The write port exists for completeness; the fetch stage ties it off.
module imem_sram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Synchronous read (read-before-write) with optional write.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: request PC, 1-cycle instruction memory, EX/ID
// redirects with one-bubble kill, stall hold with instruction capture.
// Optional feature macro: IF_MISALIGN_CHECK_EN (flags misaligned pc_o).
module pipeline_fetch
    import pipeline_fetch_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEF,
    parameter int               IMEM_DEPTH = 1024,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stall_i,
    input  logic [XLEN-1:0] redirect_d_i,
    input  logic            taken_d_i,
    input  logic [XLEN-1:0] redirect_e_i,
    input  logic            taken_e_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic            misalign_o
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic            valid_r;
    logic [XLEN-1:0] hold_r;
    logic            hold_valid_r;
    logic [AW-1:0]   mem_addr_s;
    logic [XLEN-1:0] mem_rdata_s;

    // Word address; upper PC bits alias modulo the memory depth.
    assign mem_addr_s = req_pc_r[AW+1:2];

    imem_sram #(
        .WIDTH (XLEN),
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .ce    (1'b1),
        .we    (1'b0),
        .addr  (mem_addr_s),
        .wdata ({XLEN{1'b0}}),
        .rdata (mem_rdata_s)
    );

    // Next-PC selection and output registers: EX redirect, ID redirect, stall, sequential.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_pc_r     <= RESET_PC;
            pc_r         <= {XLEN{1'b0}};
            pc_plus4_r   <= {XLEN{1'b0}};
            valid_r      <= 1'b0;
            hold_r       <= {XLEN{1'b0}};
            hold_valid_r <= 1'b0;
        end else if (taken_e_i) begin
            // The fetch in flight is wrong-path; kill it and drop any held word.
            req_pc_r     <= redirect_e_i;
            valid_r      <= 1'b0;
            hold_valid_r <= 1'b0;
        end else if (taken_d_i && !stall_i) begin
            req_pc_r     <= redirect_d_i;
            valid_r      <= 1'b0;
            hold_valid_r <= 1'b0;
        end else if (stall_i) begin
            // The memory keeps reading req_pc, so freeze the word ID is looking at.
            if (!hold_valid_r) begin
                hold_r       <= mem_rdata_s;
                hold_valid_r <= 1'b1;
            end
        end else begin
            pc_r         <= req_pc_r;
            pc_plus4_r   <= req_pc_r + XLEN'(PC_INC);
            valid_r      <= 1'b1;
            req_pc_r     <= req_pc_r + XLEN'(PC_INC);
            hold_valid_r <= 1'b0;
        end
    end

    assign instr_o    = hold_valid_r ? hold_r : mem_rdata_s;
    assign pc_o       = pc_r;
    assign pc_plus4_o = pc_plus4_r;
    assign valid_o    = valid_r;

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign_o = valid_r & pc_misaligned(pc_r[1:0]);
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Scoreboard bench for pipeline_fetch: a behavioural fetch model pushes the
// expected output record for each driven cycle; it is popped and compared
// one time step after the clock edge.
module tb_pipeline_fetch;
    import pipeline_fetch_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall_i;
    logic [31:0] redirect_d_i;
    logic        taken_d_i;
    logic [31:0] redirect_e_i;
    logic        taken_e_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [DEPTH];

    // Reference model state.
    logic [31:0] m_req;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic        m_valid;

    fetch_out_t exp_q [$];
    logic       exp_mis_q [$];

    pipeline_fetch #(
        .XLEN       (32),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall_i      (stall_i),
        .redirect_d_i (redirect_d_i),
        .taken_d_i    (taken_d_i),
        .redirect_e_i (redirect_e_i),
        .taken_e_i    (taken_e_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .valid_o      (valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic rn, input logic st, input logic td, input logic [31:0] rd,
                        input logic te, input logic [31:0] re);
        fetch_out_t e;
        fetch_out_t o;
        logic       emis;
        @(negedge clk);
        resetn       = rn;
        stall_i      = st;
        taken_d_i    = td;
        redirect_d_i = rd;
        taken_e_i    = te;
        redirect_e_i = re;
        if (!rn) begin
            m_req = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (te) begin
            m_req = re; m_valid = 1'b0;
        end else if (td && !st) begin
            m_req = rd; m_valid = 1'b0;
        end else if (!st) begin
            m_pc = m_req; m_pc4 = m_req + 32'd4; m_valid = 1'b1; m_req = m_req + 32'd4;
        end
        e.instr    = mem_m[(m_pc >> 2) % DEPTH];
        e.pc       = m_pc;
        e.pc_plus4 = m_pc4;
        e.valid    = m_valid;
`ifdef IF_MISALIGN_CHECK_EN
        emis = m_valid && (m_pc[1:0] != 2'b00);
`else
        emis = 1'b0;
`endif
        exp_q.push_back(e);
        exp_mis_q.push_back(emis);
        @(posedge clk);
        #1;
        o    = exp_q.pop_front();
        emis = exp_mis_q.pop_front();
        check("valid", 32'(valid_o), 32'(o.valid));
        check("misalign", 32'(misalign_o), 32'(emis));
        if (!rn) begin
            check("rst_pc", pc_o, 32'h0);
            check("rst_pc4", pc_plus4_o, 32'h0);
        end
        if (o.valid) begin
            check("pc", pc_o, o.pc);
            check("pc_plus4", pc_plus4_o, o.pc_plus4);
            check("instr", instr_o, o.instr);
        end
    endtask

    task automatic run(input logic st);
        step(1'b1, st, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        resetn = 1'b0; stall_i = 1'b0; taken_d_i = 1'b0; taken_e_i = 1'b0;
        redirect_d_i = 32'h0; redirect_e_i = 32'h0;
        m_req = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = $urandom() ^ (32'(i) << 24);
            dut.u_imem.mem_r[i] <= mem_m[i];
        end
        #1;

        // Reset state, then free-running fetch 0,4,8,C.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) run(1'b0);

        // Stall three cycles at pc 8, release with no bubble.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) run(1'b0);
        for (int i = 0; i < 3; i++) run(1'b1);
        run(1'b0);
        run(1'b0);

        // ID redirect to 0x40 at pc 8: one bubble, then mem[16].
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) run(1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        run(1'b0);
        run(1'b0);

        // ID redirect ignored while stalled; EX wins over ID during stall.
        run(1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
        run(1'b0);
        run(1'b0);

        // PC wrap-around at the top of the address space.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        run(1'b0);
        run(1'b0);

        // Misaligned redirect fetches from the truncated word address.
        step(1'b1, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
        run(1'b0);
        run(1'b0);

        // Stall directly after a redirect, then reset during a stall.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        run(1'b1);
        run(1'b1);
        run(1'b0);
        run(1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h90);
        run(1'b0);

        // Random mix of stalls, redirects and occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic        rn, st, td, te;
            logic [31:0] rd, re;
            rn = ($urandom_range(0, 99) >= 2);
            st = ($urandom_range(0, 99) < 30);
            td = ($urandom_range(0, 99) < 15);
            te = ($urandom_range(0, 99) < 10);
            rd = 32'($urandom_range(0, 255)) << 2;
            re = 32'($urandom_range(0, 255)) << 2;
            step(rn, st, td, rd, te, re);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_fetch.md
PIPELINE_FETCH -- requirements
Module: pipeline_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 1024, instruction memory depth in words; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port stall_i  input  1  ID not accepting; hold the current output.
REQ-007 SHALL have port redirect_d_i  input  XLEN  ID static-predictor target.
REQ-008 SHALL have port taken_d_i  input  1  ID redirect request.
REQ-009 SHALL have port redirect_e_i  input  XLEN  EX mispredict-correction target.
REQ-010 SHALL have port taken_e_i  input  1  EX redirect request.
REQ-011 SHALL have port instr_o  output  XLEN  fetched instruction.
REQ-012 SHALL have port pc_o  output  XLEN  PC of instr_o.
REQ-013 SHALL have port pc_plus4_o  output  XLEN  pc_o + 4, modulo 2^XLEN.
REQ-014 SHALL have port valid_o  output  1  instr_o/pc_o hold a live, right-path instruction.
REQ-015 SHALL have port misalign_o  output  1  pc_o[1:0] != 0; always present.

Function
REQ-016 SHALL keep a request PC, req_pc, and drive the memory word address req_pc[clog2(IMEM_DEPTH)+1:2]. Higher bits alias modulo IMEM_DEPTH.
REQ-017 Memory read latency SHALL be exactly 1 cycle. Memory is read-only: write enable inactive, chip enable always active.
REQ-018 Next-PC priority SHALL be: taken_e_i, then (taken_d_i and not stall_i), then stall hold, then sequential req_pc+4.
REQ-019 On a normal edge (no redirect, no stall): pc_o<=req_pc, pc_plus4_o<=req_pc+4, valid_o<=1, req_pc<=req_pc+4.
REQ-020 On a redirect edge: req_pc<=target and valid_o<=0, so the in-flight wrong-path fetch is killed. The next edge presents the target with valid_o=1, giving a 1-bubble penalty.
REQ-021 taken_e_i SHALL be honoured regardless of stall_i, and SHALL clear any held instruction.
REQ-022 taken_d_i SHALL be ignored while stall_i=1; ID re-presents the branch.
REQ-023 While stall_i=1 and no EX redirect: pc_o, pc_plus4_o, valid_o, instr_o and req_pc SHALL hold.
REQ-024 On the first stall cycle, the memory output SHALL be captured in a hold register, and instr_o SHALL source from it until stall releases.
REQ-025 The edge where stall_i=0 SHALL present mem[req_pc] with zero bubbles.
REQ-026 PC arithmetic SHALL wrap modulo 2^XLEN; PC 32'hFFFF_FFFC is followed by 32'h0.
REQ-027 When taken_e_i and taken_d_i are both asserted, redirect_e_i SHALL win.

Reset
REQ-028 While resetn=0 at an edge: req_pc<=RESET_PC, pc_o<=0, pc_plus4_o<=0, valid_o<=0, hold register cleared, misalign_o=0.
REQ-029 The first edge with resetn=1 SHALL present pc_o=RESET_PC with valid_o=1.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL override all of it.

Configuration
REQ-031 Macro IF_MISALIGN_CHECK_EN defined: misalign_o = valid_o & (pc_o[1:0]!=0). Such instructions are still fetched from the truncated word address.
REQ-032 Macro IF_MISALIGN_CHECK_EN undefined: misalign_o SHALL be tied 0.

Structure
REQ-033 A shared package SHALL hold the XLEN default, the RESET_PC default, the PC increment constant 4, and the fetch-output record type (instr, pc, pc_plus4, valid).
REQ-034 Sub-module imem_sram SHALL be a parameterised single-port synchronous read memory (width XLEN, depth IMEM_DEPTH, 1-cycle latency).

Verification
REQ-035 Reset, then 4 free cycles, RESET_PC=0 -> pc_o 0,4,8,C; valid_o 1 from the first cycle; instr_o = mem[0..3].
REQ-036 Straight-line fetch with stall_i=1 for 3 cycles while pc_o=8 -> pc_o=8 and instr_o=mem[2] held; after release pc_o=C with no bubble.
REQ-037 taken_d_i=1, redirect_d_i=0x40 at pc_o=8 -> next cycle valid_o=0; following cycle pc_o=0x40, instr_o=mem[16].
REQ-038 taken_e_i=1 (target 0x100) with taken_d_i=1 (target 0x40) during stall -> pc_o=0x100 after 1 bubble; hold register discarded.
REQ-039 IMEM_DEPTH=16, fetch reaches 0x40 -> instr_o=mem[0] (alias); PC 0xFFFF_FFFC is followed by 0x0.
REQ-040 With IF_MISALIGN_CHECK_EN, redirect to 0x42 -> misalign_o=1, pc_o=0x42, instr_o=mem[16]. Without the macro, misalign_o=0.
